// File: rtl/ysyx_23060236_wbu_if.sv
// Signal bundle between the WBU and its neighbours: LSU write-back, IDU issue/cancel,
// register read ports and retire status.
interface ysyx_23060236_wbu_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  wb_valid;
   logic [31:0]           wb_val;
   logic [ADDR_WIDTH-1:0] wb_rd;
   logic                  wb_wen;
   logic                  issue_valid;
   logic [ADDR_WIDTH-1:0] issue_rd;
   logic                  issue_wen;
   logic                  cancel_valid;
   logic [ADDR_WIDTH-1:0] cancel_rd;
   logic [ADDR_WIDTH-1:0] raddr1;
   logic [ADDR_WIDTH-1:0] raddr2;
   logic [31:0]           rdata1;
   logic [31:0]           rdata2;
   logic                  rs1_busy;
   logic                  rs2_busy;
   logic                  issue_stall;
   logic                  retire;
   logic [63:0]           retire_cnt;
   logic                  sb_err;

   modport master (
      output wb_valid, wb_val, wb_rd, wb_wen,
      output issue_valid, issue_rd, issue_wen,
      output cancel_valid, cancel_rd,
      output raddr1, raddr2,
      input  rdata1, rdata2, rs1_busy, rs2_busy, issue_stall,
      input  retire, retire_cnt, sb_err
   );

   modport slave (
      input  wb_valid, wb_val, wb_rd, wb_wen,
      input  issue_valid, issue_rd, issue_wen,
      input  cancel_valid, cancel_rd,
      input  raddr1, raddr2,
      output rdata1, rdata2, rs1_busy, rs2_busy, issue_stall,
      output retire, retire_cnt, sb_err
   );
endinterface

// File: rtl/ysyx_23060236_wbu.sv
// Write-back stage: register file with write-through read bypass, per-register
// in-flight writer scoreboard for RAW stalls, and retire pulse/counter.
module ysyx_23060236_wbu #(
   parameter int REG_NUM    = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_WIDTH  = 2
) (
   input  logic               clock,
   input  logic               reset,
   ysyx_23060236_wbu_if.slave bus
);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [31:0]          r_regs [REG_NUM];
   logic [CNT_WIDTH-1:0] r_cnt  [REG_NUM];
   logic                 r_retire;
   logic [63:0]          r_retire_cnt;
   logic                 r_sb_err;

   logic                 w_wr_en;
   logic                 w_ret_rs1;
   logic                 w_ret_rs2;
   logic                 w_ret_issue;
   logic [31:0]          w_rdata1;
   logic [31:0]          w_rdata2;
   logic [CNT_WIDTH-1:0] w_cnt_nxt [REG_NUM];
   logic                 w_sb_err_set;

   assign w_wr_en     = bus.wb_valid & bus.wb_wen & (bus.wb_rd != '0);
   assign w_ret_rs1   = bus.wb_valid & bus.wb_wen & (bus.wb_rd == bus.raddr1);
   assign w_ret_rs2   = bus.wb_valid & bus.wb_wen & (bus.wb_rd == bus.raddr2);
   assign w_ret_issue = bus.wb_valid & bus.wb_wen & (bus.wb_rd == bus.issue_rd);

   // NOTE: every always_comb output is given a default before any branch so no latch is inferred.
   always_comb begin
      w_rdata1 = r_regs[bus.raddr1];
      if (bus.raddr1 == '0)                          w_rdata1 = '0;
      else if (w_wr_en && bus.wb_rd == bus.raddr1)   w_rdata1 = bus.wb_val;
   end

   always_comb begin
      w_rdata2 = r_regs[bus.raddr2];
      if (bus.raddr2 == '0)                          w_rdata2 = '0;
      else if (w_wr_en && bus.wb_rd == bus.raddr2)   w_rdata2 = bus.wb_val;
   end

   // Net change per register, widened by two bits so both underflow and overflow are visible.
   always_comb begin
      logic [CNT_WIDTH+1:0] v_sum;
      logic                 v_inc;
      logic                 v_dec_wb;
      logic                 v_dec_cn;
      v_sum        = '0;
      v_inc        = 1'b0;
      v_dec_wb     = 1'b0;
      v_dec_cn     = 1'b0;
      w_sb_err_set = 1'b0;
      w_cnt_nxt[0] = '0;
      for (int i = 1; i < REG_NUM; i++) begin
         v_inc    = bus.issue_valid & bus.issue_wen & (bus.issue_rd == ADDR_WIDTH'(i));
         v_dec_wb = bus.wb_valid & bus.wb_wen & (bus.wb_rd == ADDR_WIDTH'(i));
         v_dec_cn = bus.cancel_valid & (bus.cancel_rd == ADDR_WIDTH'(i));
         v_sum    = {2'b00, r_cnt[i]} + (CNT_WIDTH+2)'(v_inc)
                  - (CNT_WIDTH+2)'(v_dec_wb) - (CNT_WIDTH+2)'(v_dec_cn);
         if (v_sum[CNT_WIDTH+1]) begin
            w_cnt_nxt[i] = '0;
            w_sb_err_set = 1'b1;
         end else if (v_sum > {2'b00, CNT_MAX}) begin
            w_cnt_nxt[i] = CNT_MAX;
            w_sb_err_set = 1'b1;
         end else begin
            w_cnt_nxt[i] = v_sum[CNT_WIDTH-1:0];
         end
      end
   end

   // NOTE: the register file is reset element by element because software may read any GPR as zero after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < REG_NUM; i++) begin
            r_regs[i] <= '0;
            r_cnt[i]  <= '0;
         end
         r_retire     <= 1'b0;
         r_retire_cnt <= '0;
         r_sb_err     <= 1'b0;
      end else begin
         if (w_wr_en) r_regs[bus.wb_rd] <= bus.wb_val;
         for (int i = 1; i < REG_NUM; i++) r_cnt[i] <= w_cnt_nxt[i];
         r_retire     <= bus.wb_valid;
         r_retire_cnt <= r_retire_cnt + 64'(bus.wb_valid);
         if (w_sb_err_set) r_sb_err <= 1'b1;
      end
   end

   assign bus.rdata1      = w_rdata1;
   assign bus.rdata2      = w_rdata2;
   assign bus.rs1_busy    = (bus.raddr1 != '0) &
                            ((r_cnt[bus.raddr1] - CNT_WIDTH'(w_ret_rs1)) != '0);
   assign bus.rs2_busy    = (bus.raddr2 != '0) &
                            ((r_cnt[bus.raddr2] - CNT_WIDTH'(w_ret_rs2)) != '0);
   assign bus.issue_stall = bus.issue_wen & (bus.issue_rd != '0) &
                            (r_cnt[bus.issue_rd] == CNT_MAX) & ~w_ret_issue;
   assign bus.retire      = r_retire;
   assign bus.retire_cnt  = r_retire_cnt;
   assign bus.sb_err      = r_sb_err;
endmodule

// File: tb/tb_ysyx_23060236_wbu.sv
// Scoreboard bench for the write-back stage: stimulus queues expectations, a
// negedge monitor compares them and checks retire_cnt on every retire pulse.
module tb_ysyx_23060236_wbu;
   typedef enum logic [2:0] {
      S_RDATA1, S_RDATA2, S_BUSY1, S_BUSY2, S_STALL, S_RETIRE, S_RETCNT, S_ERR
   } sel_e;

   typedef struct {
      int          cyc;
      sel_e        sel;
      logic [63:0] exp;
      string       name;
   } chk_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   chk_t        eq[$];
   logic [63:0] rq[$];
   logic [31:0] ref_regs [16];
   logic [63:0] model_cnt;

   ysyx_23060236_wbu_if #(.ADDR_WIDTH(4)) bus ();

   ysyx_23060236_wbu #(
      .REG_NUM   (16),
      .ADDR_WIDTH(4),
      .CNT_WIDTH (2)
   ) dut (
      .clock(clk),
      .reset(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] actual(input sel_e s);
      case (s)
         S_RDATA1: return 64'(bus.rdata1);
         S_RDATA2: return 64'(bus.rdata2);
         S_BUSY1:  return 64'(bus.rs1_busy);
         S_BUSY2:  return 64'(bus.rs2_busy);
         S_STALL:  return 64'(bus.issue_stall);
         S_RETIRE: return 64'(bus.retire);
         S_RETCNT: return bus.retire_cnt;
         default:  return 64'(bus.sb_err);
      endcase
   endfunction

   // Monitor: per-cycle expectations plus a retire_cnt check on every retire pulse.
   always @(negedge clk) begin
      while (eq.size() > 0 && eq[0].cyc <= cyc) begin
         chk_t c;
         c = eq.pop_front();
         check(c.name, actual(c.sel), c.exp);
      end
      if (bus.retire === 1'b1) begin
         if (rq.size() == 0) check("retire_unexpected", 64'(bus.retire), 64'd0);
         else                check("retire_cnt", bus.retire_cnt, rq.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wb_valid     = 1'b0;
      bus.wb_val       = '0;
      bus.wb_rd        = '0;
      bus.wb_wen       = 1'b0;
      bus.issue_valid  = 1'b0;
      bus.issue_rd     = '0;
      bus.issue_wen    = 1'b0;
      bus.cancel_valid = 1'b0;
      bus.cancel_rd    = '0;
      bus.raddr1       = '0;
      bus.raddr2       = '0;
   endtask

   task automatic expect_now(input sel_e s, input logic [63:0] v, input string nm);
      chk_t c;
      c.cyc  = cyc;
      c.sel  = s;
      c.exp  = v;
      c.name = nm;
      eq.push_back(c);
   endtask

   task automatic drive_wb(input logic wen, input logic [3:0] rd, input logic [31:0] val);
      bus.wb_valid = 1'b1;
      bus.wb_wen   = wen;
      bus.wb_rd    = rd;
      bus.wb_val   = val;
      model_cnt    = model_cnt + 64'd1;
      rq.push_back(model_cnt);
   endtask

   task automatic issue(input logic [3:0] rd);
      bus.issue_valid = 1'b1;
      bus.issue_wen   = 1'b1;
      bus.issue_rd    = rd;
   endtask

   function automatic logic [31:0] model_read(input logic [3:0] a, input logic wr,
                                              input logic [3:0] rd, input logic [31:0] val);
      if (a == 4'd0)              return 32'd0;
      if (wr && rd == a)          return val;
      return ref_regs[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 16; i++) ref_regs[i] = '0;
      model_cnt = '0;
   endtask

   initial begin
      int          pulses;
      logic        wen;
      logic [3:0]  rd;
      logic [31:0] val;
      logic [31:0] e1, e2;

      clear_model();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state.
      bus.raddr1 = 4'd5;
      expect_now(S_RETIRE, 0, "reset_retire");
      expect_now(S_RETCNT, 0, "reset_retire_cnt");
      expect_now(S_ERR,    0, "reset_sb_err");
      expect_now(S_RDATA1, 0, "reset_regs5");
      expect_now(S_BUSY1,  0, "reset_busy5");

      // Bypass: issue x5, then retire it while reading x5.
      tick(); idle_inputs();
      issue(4'd5);
      tick(); idle_inputs();
      drive_wb(1'b1, 4'd5, 32'hDEADBEEF); ref_regs[5] = 32'hDEADBEEF;
      bus.raddr1 = 4'd5;
      expect_now(S_RDATA1, 64'hDEADBEEF, "bypass_rdata1");
      expect_now(S_BUSY1,  0,            "bypass_no_busy");
      tick(); idle_inputs();
      bus.raddr1 = 4'd5;
      expect_now(S_RDATA1, 64'hDEADBEEF, "regfile_rdata1");
      expect_now(S_RETIRE, 1,            "retire_pulse");
      expect_now(S_RETCNT, 1,            "retire_cnt_1");

      // x0: write and issue to x0 are ignored.
      tick(); idle_inputs();
      drive_wb(1'b1, 4'd0, 32'h1234);
      issue(4'd0);
      bus.raddr1 = 4'd0;
      expect_now(S_RDATA1, 0, "x0_bypass");
      expect_now(S_BUSY1,  0, "x0_busy");
      expect_now(S_STALL,  0, "x0_stall");
      tick(); idle_inputs();
      bus.raddr1 = 4'd0; bus.raddr2 = 4'd5;
      expect_now(S_RDATA1, 0,            "x0_read");
      expect_now(S_RDATA2, 64'hDEADBEEF, "rdata2_x5");
      expect_now(S_ERR,    0,            "x0_no_err");

      // Saturation of x3 and drain by retires.
      tick(); idle_inputs(); issue(4'd3);
      tick(); idle_inputs(); issue(4'd3);
      tick(); idle_inputs(); issue(4'd3);
      expect_now(S_STALL, 0, "stall_below_max");
      tick(); idle_inputs();
      bus.issue_wen = 1'b1; bus.issue_rd = 4'd3; bus.raddr1 = 4'd3; bus.raddr2 = 4'd3;
      expect_now(S_BUSY1, 1, "sat_busy1");
      expect_now(S_BUSY2, 1, "sat_busy2");
      expect_now(S_STALL, 1, "sat_stall");
      tick(); idle_inputs();
      bus.issue_wen = 1'b1; bus.issue_rd = 4'd3; bus.raddr1 = 4'd3;
      drive_wb(1'b1, 4'd3, 32'h33); ref_regs[3] = 32'h33;
      expect_now(S_STALL, 0, "stall_released_by_retire");
      expect_now(S_BUSY1, 1, "busy_two_left");
      tick(); idle_inputs();
      bus.raddr1 = 4'd3;
      drive_wb(1'b1, 4'd3, 32'h44); ref_regs[3] = 32'h44;
      expect_now(S_BUSY1, 1, "busy_one_left");
      tick(); idle_inputs();
      bus.raddr1 = 4'd3;
      drive_wb(1'b1, 4'd3, 32'h55); ref_regs[3] = 32'h55;
      expect_now(S_BUSY1,  0,        "busy_clear_last_retire");
      expect_now(S_RDATA1, 64'h55,   "last_write_wins");
      expect_now(S_RETIRE, 1,        "retire_back_to_back");
      tick(); idle_inputs();
      bus.raddr1 = 4'd3;
      expect_now(S_BUSY1,  0,        "busy_clear_after");
      expect_now(S_RDATA1, 64'h55,   "x3_final");
      expect_now(S_ERR,    0,        "drain_no_err");

      // Issue, cancel and retire on x7 in one cycle.
      tick(); idle_inputs(); issue(4'd7);
      tick(); idle_inputs();
      issue(4'd7);
      bus.cancel_valid = 1'b1; bus.cancel_rd = 4'd7;
      drive_wb(1'b1, 4'd7, 32'h77); ref_regs[7] = 32'h77;
      bus.raddr1 = 4'd7;
      expect_now(S_RDATA1, 64'h77, "triple_bypass");
      tick(); idle_inputs();
      bus.raddr1 = 4'd7;
      expect_now(S_BUSY1, 0, "triple_cnt_zero");
      expect_now(S_ERR,   0, "triple_no_err");

      // Cancel alone: busy holds in the cancel cycle, clears next.
      tick(); idle_inputs(); issue(4'd8);
      tick(); idle_inputs();
      bus.cancel_valid = 1'b1; bus.cancel_rd = 4'd8; bus.raddr2 = 4'd8;
      expect_now(S_BUSY2, 1, "cancel_busy_same_cycle");
      tick(); idle_inputs();
      bus.raddr2 = 4'd8;
      expect_now(S_BUSY2, 0, "cancel_busy_next_cycle");

      // Underflow on x9.
      tick(); idle_inputs();
      drive_wb(1'b1, 4'd9, 32'h99); ref_regs[9] = 32'h99;
      tick(); idle_inputs();
      bus.raddr1 = 4'd9;
      expect_now(S_ERR,    1,      "underflow_err");
      expect_now(S_BUSY1,  0,      "underflow_cnt_zero");
      expect_now(S_RDATA1, 64'h99, "underflow_write");
      tick(); idle_inputs();
      expect_now(S_ERR, 1, "sb_err_sticky");

      // Reset with an in-flight write that must be discarded.
      tick(); idle_inputs();
      rst = 1'b1;
      bus.wb_valid = 1'b1; bus.wb_wen = 1'b1; bus.wb_rd = 4'd5; bus.wb_val = 32'hFFFF;
      tick(); idle_inputs();
      rst = 1'b0;
      clear_model();
      bus.raddr1 = 4'd5; bus.raddr2 = 4'd9;
      expect_now(S_ERR,    0, "reset_clears_err");
      expect_now(S_RETCNT, 0, "reset_clears_cnt");
      expect_now(S_RETIRE, 0, "reset_drops_retire");
      expect_now(S_RDATA1, 0, "reset_clears_x5");
      expect_now(S_RDATA2, 0, "reset_clears_x9");

      // Stress: 1000 wb_valid pulses with random gaps and wb_wen.
      pulses = 0;
      while (pulses < 1000) begin
         tick(); idle_inputs();
         bus.raddr1 = 4'($urandom_range(0, 15));
         bus.raddr2 = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) begin
            wen = ($urandom_range(0, 3) != 0);
            rd  = 4'($urandom_range(0, 15));
            val = $urandom;
            e1  = model_read(bus.raddr1, wen, rd, val);
            e2  = model_read(bus.raddr2, wen, rd, val);
            drive_wb(wen, rd, val);
            if (wen && rd != 4'd0) ref_regs[rd] = val;
            pulses++;
         end else begin
            e1 = model_read(bus.raddr1, 1'b0, 4'd0, 32'd0);
            e2 = model_read(bus.raddr2, 1'b0, 4'd0, 32'd0);
         end
         expect_now(S_RDATA1, 64'(e1), "stress_rdata1");
         expect_now(S_RDATA2, 64'(e2), "stress_rdata2");
      end
      tick(); idle_inputs();
      expect_now(S_RETCNT, 64'd1000, "stress_retire_cnt");
      for (int i = 0; i < 8; i++) begin
         tick(); idle_inputs();
         bus.raddr1 = 4'(i);
         bus.raddr2 = 4'(i + 8);
         expect_now(S_RDATA1, 64'(ref_regs[i]),     "final_regs_lo");
         expect_now(S_RDATA2, 64'(ref_regs[i + 8]), "final_regs_hi");
      end
      tick(); idle_inputs();
      tick();
      check("retire_missing", 64'(rq.size()), 64'd0);
      check("expect_undrained", 64'(eq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
